// File: rtl/xadc_drp_sampler_if.sv
// xadc_drp_sampler_if: XADC DRP bus plus the signed sample stream toward the scaling stage
interface xadc_drp_sampler_if;
   logic               den_out;
   logic [6:0]         daddr_out;
   logic               dwe_out;
   logic [15:0]        di_out;
   logic               drdy_in;
   logic [15:0]        do_in;
   logic signed [11:0] sampleOUT;
   logic               SAMPLEoutReady;
   modport master (
      output den_out, daddr_out, dwe_out, di_out, sampleOUT, SAMPLEoutReady,
      input  drdy_in, do_in
   );
   modport slave (
      input  den_out, daddr_out, dwe_out, di_out, sampleOUT, SAMPLEoutReady,
      output drdy_in, do_in
   );
endinterface

// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler: on each XADC EOC reads one DRP channel and emits a signed, decimated sample strobe
module xadc_drp_sampler #(
   parameter logic [6:0] CHANNEL_ADDR = 7'h03,
   parameter int         SAMPLE_WIDTH = 12,
   parameter bit         BIPOLAR      = 1'b1,
   parameter int         DRDY_TIMEOUT = 64,
   parameter int         DECIMATION   = 1
) (
   input  logic                      CLK104MHZ,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      eoc_in,
   xadc_drp_sampler_if.master        drp,
   output logic                      overrun,
   output logic                      timeout_err,
   output logic [15:0]               sample_count
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, EMIT} state_t;
   state_t state, state_n;
   logic eoc_r, eoc_d, ev, hit, tmo;
   logic [15:0] tcnt;
   logic [7:0] dcnt;
   logic [11:0] code;
   logic signed [SAMPLE_WIDTH-1:0] sample_r;
   assign ev   = eoc_r & ~eoc_d;
   assign code = drp.do_in[15:4];
   assign hit  = dcnt == 8'(DECIMATION - 1);
   assign tmo  = tcnt == 16'(DRDY_TIMEOUT - 1);
   always_ff @(posedge CLK104MHZ)
      if (!rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = IDLE;
      unique case (state)
         IDLE:    state_n = ev && enable ? REQ : IDLE;
         REQ:     state_n = WAIT;
         WAIT:    state_n = drp.drdy_in ? (enable && hit ? EMIT : IDLE) : tmo ? IDLE : WAIT;
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      drp.den_out        = state == REQ;
      drp.SAMPLEoutReady = state == EMIT;
      drp.daddr_out      = CHANNEL_ADDR;
      drp.dwe_out        = 1'b0;
      drp.di_out         = '0;
      drp.sampleOUT      = sample_r;
   end
   // a read started before enable dropped still runs to drdy, but its code is discarded
   always_ff @(posedge CLK104MHZ)
      if (!rst) begin
         eoc_r        <= 1'b0;
         eoc_d        <= 1'b0;
         tcnt         <= '0;
         dcnt         <= '0;
         sample_r     <= '0;
         overrun      <= 1'b0;
         timeout_err  <= 1'b0;
         sample_count <= '0;
      end else begin
         eoc_r <= eoc_in;
         eoc_d <= eoc_r;
         tcnt  <= state == WAIT ? tcnt + 16'd1 : '0;
         if (ev && state != IDLE) overrun <= 1'b1;
         if (state == WAIT && !drp.drdy_in && tmo) timeout_err <= 1'b1;
         if (state == WAIT && drp.drdy_in && enable) begin
            if (hit) sample_r <= BIPOLAR ? code : {~code[11], code[10:0]};
            else dcnt <= dcnt + 8'd1;
         end
         if (state == EMIT) begin
            sample_count <= sample_count + 16'd1;
            dcnt         <= '0;
         end
      end
endmodule

// File: tb/tb_xadc_drp_sampler.sv
// tb_xadc_drp_sampler: directed checks of bipolar, unipolar, decimating and timeout/overrun behaviour
module tb_xadc_drp_sampler;
   logic clk = 1'b0, rst = 1'b0, enable = 1'b1, eoc = 1'b0, drdy = 1'b0;
   logic [15:0] dat = '0;
   logic [15:0] cnt0, cnt1, cnt2;
   logic ovr0, ovr1, ovr2, tmo0, tmo1, tmo2;
   int vectors = 0, errors = 0;
   int s0 = 0, s2 = 0, d0 = 0;
   always #5 clk = ~clk;
   xadc_drp_sampler_if if0 ();
   xadc_drp_sampler_if if1 ();
   xadc_drp_sampler_if if2 ();
   assign if0.drdy_in = drdy;
   assign if1.drdy_in = drdy;
   assign if2.drdy_in = drdy;
   assign if0.do_in = dat;
   assign if1.do_in = dat;
   assign if2.do_in = dat;
   xadc_drp_sampler #(.BIPOLAR(1'b1), .DRDY_TIMEOUT(8), .DECIMATION(1)) u_bip (
      .CLK104MHZ(clk), .rst(rst), .enable(enable), .eoc_in(eoc), .drp(if0),
      .overrun(ovr0), .timeout_err(tmo0), .sample_count(cnt0));
   xadc_drp_sampler #(.BIPOLAR(1'b0), .DRDY_TIMEOUT(8), .DECIMATION(1)) u_uni (
      .CLK104MHZ(clk), .rst(rst), .enable(enable), .eoc_in(eoc), .drp(if1),
      .overrun(ovr1), .timeout_err(tmo1), .sample_count(cnt1));
   xadc_drp_sampler #(.BIPOLAR(1'b1), .DRDY_TIMEOUT(8), .DECIMATION(4)) u_dec (
      .CLK104MHZ(clk), .rst(rst), .enable(enable), .eoc_in(eoc), .drp(if2),
      .overrun(ovr2), .timeout_err(tmo2), .sample_count(cnt2));
   always @(posedge clk) begin
      if (if0.SAMPLEoutReady) s0 <= s0 + 1;
      if (if2.SAMPLEoutReady) s2 <= s2 + 1;
      if (if0.den_out) d0 <= d0 + 1;
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic eoc_pulse();
      eoc = 1'b1;
      tick();
      eoc = 1'b0;
   endtask
   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask
   // leaves the bench in the cycle right after drdy (EMIT when a sample is due)
   task automatic read(input logic [15:0] d, input int gap);
      eoc_pulse();
      tick();
      tick();
      repeat (gap) tick();
      drdy = 1'b1;
      dat = d;
      tick();
      drdy = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      vectors++; if (if0.den_out !== 1'b0) begin errors++; $display("FAIL reset_den got %b exp 0", if0.den_out); end
      vectors++; if (if0.daddr_out !== 7'h03) begin errors++; $display("FAIL reset_daddr got %h exp 03", if0.daddr_out); end
      vectors++; if (if0.sampleOUT !== 12'sd0) begin errors++; $display("FAIL reset_sample got %0d exp 0", if0.sampleOUT); end
      vectors++; if (if0.SAMPLEoutReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", if0.SAMPLEoutReady); end
      vectors++; if (ovr0 !== 1'b0 || tmo0 !== 1'b0) begin errors++; $display("FAIL reset_flags got ovr=%b tmo=%b exp 0 0", ovr0, tmo0); end
      vectors++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt0); end
   endtask
   task automatic test_bipolar();
      int dstart;
      dstart = d0;
      eoc_pulse();
      tick();
      vectors++; if (if0.den_out !== 1'b1 || if0.daddr_out !== 7'h03) begin errors++; $display("FAIL bip_den got den=%b addr=%h exp 1 03", if0.den_out, if0.daddr_out); end
      vectors++; if (if0.dwe_out !== 1'b0 || if0.di_out !== 16'h0) begin errors++; $display("FAIL bip_nowrite got dwe=%b di=%h exp 0 0000", if0.dwe_out, if0.di_out); end
      tick();
      vectors++; if (if0.den_out !== 1'b0) begin errors++; $display("FAIL bip_den_once got %b exp 0", if0.den_out); end
      tick();
      tick();
      drdy = 1'b1;
      dat = 16'hFFF0;
      tick();
      drdy = 1'b0;
      vectors++; if (if0.SAMPLEoutReady !== 1'b1 || if0.sampleOUT !== -12'sd1) begin errors++; $display("FAIL bip_sample got rdy=%b val=%0d exp 1 -1", if0.SAMPLEoutReady, if0.sampleOUT); end
      tick();
      vectors++; if (if0.SAMPLEoutReady !== 1'b0 || if0.sampleOUT !== -12'sd1) begin errors++; $display("FAIL bip_hold got rdy=%b val=%0d exp 0 -1", if0.SAMPLEoutReady, if0.sampleOUT); end
      vectors++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL bip_count got %0d exp 1", cnt0); end
      vectors++; if (d0 - dstart !== 1) begin errors++; $display("FAIL bip_den_count got %0d exp 1", d0 - dstart); end
   endtask
   task automatic test_unipolar();
      logic [11:0] codes [3] = '{12'h000, 12'h800, 12'hFFF};
      logic signed [11:0] exps [3] = '{-12'sd2048, 12'sd0, 12'sd2047};
      for (int i = 0; i < 3; i++) begin
         read({codes[i], 4'h0}, 1);
         vectors++; if (if1.SAMPLEoutReady !== 1'b1 || if1.sampleOUT !== exps[i]) begin errors++; $display("FAIL uni_%0d got rdy=%b val=%0d exp 1 %0d", i, if1.SAMPLEoutReady, if1.sampleOUT, exps[i]); end
         tick();
      end
   endtask
   task automatic test_decimation();
      int sstart;
      logic [11:0] c;
      do_reset();
      sstart = s2;
      for (int i = 0; i < 8; i++) begin
         c = 12'h0A5 + 12'(i) * 12'h111;
         read({c, 4'h0}, 0);
         vectors++; if (if2.SAMPLEoutReady !== (i % 4 == 3)) begin errors++; $display("FAIL dec_strobe_%0d got %b exp %b", i, if2.SAMPLEoutReady, i % 4 == 3); end
         if (i % 4 == 3) begin
            vectors++; if (if2.sampleOUT !== c) begin errors++; $display("FAIL dec_value_%0d got %h exp %h", i, if2.sampleOUT, c); end
         end
         tick();
      end
      vectors++; if (s2 - sstart !== 2 || cnt2 !== 16'd2) begin errors++; $display("FAIL dec_total got strobes=%0d count=%0d exp 2 2", s2 - sstart, cnt2); end
   endtask
   task automatic test_timeout();
      int sstart;
      do_reset();
      sstart = s0;
      eoc_pulse();
      tick();
      tick();
      repeat (7) tick();
      vectors++; if (tmo0 !== 1'b0) begin errors++; $display("FAIL tmo_early got %b exp 0", tmo0); end
      tick();
      vectors++; if (tmo0 !== 1'b1) begin errors++; $display("FAIL tmo_set got %b exp 1", tmo0); end
      vectors++; if (s0 - sstart !== 0) begin errors++; $display("FAIL tmo_nostrobe got %0d exp 0", s0 - sstart); end
      read(16'h1230, 1);
      vectors++; if (if0.SAMPLEoutReady !== 1'b1 || if0.sampleOUT !== 12'sh123) begin errors++; $display("FAIL tmo_recover got rdy=%b val=%h exp 1 123", if0.SAMPLEoutReady, if0.sampleOUT); end
      tick();
      vectors++; if (tmo0 !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", tmo0); end
   endtask
   task automatic test_overrun();
      int sstart, dstart;
      do_reset();
      sstart = s0;
      dstart = d0;
      eoc_pulse();
      tick();
      tick();
      eoc_pulse();
      tick();
      vectors++; if (ovr0 !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", ovr0); end
      drdy = 1'b1;
      dat = 16'h0550;
      tick();
      drdy = 1'b0;
      vectors++; if (if0.SAMPLEoutReady !== 1'b1 || if0.sampleOUT !== 12'sh055) begin errors++; $display("FAIL ovr_sample got rdy=%b val=%h exp 1 055", if0.SAMPLEoutReady, if0.sampleOUT); end
      repeat (5) tick();
      vectors++; if (d0 - dstart !== 1 || s0 - sstart !== 1) begin errors++; $display("FAIL ovr_single got den=%0d strobes=%0d exp 1 1", d0 - dstart, s0 - sstart); end
   endtask
   task automatic test_reset_mid_read();
      int sstart;
      sstart = s0;
      eoc_pulse();
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      drdy = 1'b1;
      dat = 16'h7770;
      tick();
      drdy = 1'b0;
      tick();
      vectors++; if (s0 - sstart !== 0 || if0.SAMPLEoutReady !== 1'b0) begin errors++; $display("FAIL rstmid_strobe got %0d exp 0", s0 - sstart); end
      vectors++; if (if0.sampleOUT !== 12'sd0 || cnt0 !== 16'd0) begin errors++; $display("FAIL rstmid_outputs got val=%h count=%0d exp 000 0", if0.sampleOUT, cnt0); end
      vectors++; if (ovr0 !== 1'b0 || tmo0 !== 1'b0 || if0.den_out !== 1'b0) begin errors++; $display("FAIL rstmid_flags got ovr=%b tmo=%b den=%b exp 0 0 0", ovr0, tmo0, if0.den_out); end
   endtask
   task automatic test_enable_mid_read();
      int sstart, dstart;
      sstart = s0;
      eoc_pulse();
      tick();
      tick();
      enable = 1'b0;
      tick();
      drdy = 1'b1;
      dat = 16'h3330;
      tick();
      drdy = 1'b0;
      vectors++; if (if0.SAMPLEoutReady !== 1'b0) begin errors++; $display("FAIL enmid_strobe got %b exp 0", if0.SAMPLEoutReady); end
      tick();
      vectors++; if (s0 - sstart !== 0 || if0.sampleOUT !== 12'sd0) begin errors++; $display("FAIL enmid_discard got strobes=%0d val=%h exp 0 000", s0 - sstart, if0.sampleOUT); end
      dstart = d0;
      eoc_pulse();
      repeat (3) tick();
      vectors++; if (d0 - dstart !== 0) begin errors++; $display("FAIL en_off_ignored got den=%0d exp 0", d0 - dstart); end
      enable = 1'b1;
   endtask
   initial begin
      test_reset();
      test_bipolar();
      test_unipolar();
      test_decimation();
      test_timeout();
      test_overrun();
      test_reset_mid_read();
      test_enable_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/xadc_drp_sampler.md
# xadc_drp_sampler

Source side of the sample stream consumed by the neural-network signal-scaling stage. It watches the XADC end-of-conversion strobe, runs one read on the XADC Dynamic Reconfiguration Port (DRP) for a fixed channel, and converts the 12-bit result to two's complement. It then presents the value as a one-cycle-valid signed sample (`sampleOUT` / `SAMPLEoutReady`). It sits between the XADC primitive and the scaling controller's `dataIN` / `SAMPLEinReady` inputs.

## Interface
Parameters:
- `CHANNEL_ADDR`, 7'h03: DRP status-register address read on every conversion (VP/VN).
- `SAMPLE_WIDTH`, 12: output sample width. Fixed at 12; other values are unsupported.
- `BIPOLAR`, 1: 1 means the XADC code is already two's complement; 0 means the code is unipolar offset binary.
- `DRDY_TIMEOUT`, 64: maximum number of cycles from `den_out` to `drdy_in` before the read is aborted.
- `DECIMATION`, 1: emit one sample per `DECIMATION` successful reads. Legal range 1..255.

Ports (name, direction, width, meaning):
- `CLK104MHZ` in 1: system clock. Also drives the XADC DCLK.
- `rst` in 1: reset, synchronous, active-low; clock `CLK104MHZ`.
- `enable` in 1: allows new reads to start.
- `eoc_in` in 1: XADC end-of-conversion.
- `den_out` out 1: DRP enable strobe.
- `daddr_out` out 7: DRP address.
- `dwe_out` out 1: DRP write enable. Tied to 0.
- `di_out` out 16: DRP write data. Tied to 0.
- `drdy_in` in 1: DRP read data valid.
- `do_in` in 16: DRP read data.
- `sampleOUT` out 12 signed: converted sample.
- `SAMPLEoutReady` out 1: one-cycle strobe; `sampleOUT` is valid in the same cycle.
- `overrun` out 1: sticky flag. An EOC arrived while a read was in flight.
- `timeout_err` out 1: sticky flag. A DRP read was aborted.
- `sample_count` out 16: number of emitted samples, wraps modulo 2^16.

## Operation
States: IDLE, REQ, WAIT, EMIT.

- **EOC detection:** `eoc_in` is registered once. An event is a rising edge of the registered value.
- **IDLE:** on an event with `enable`=1, go to REQ. Events with `enable`=0 are ignored.
- **REQ:** `den_out`=1 for exactly this one cycle, with `daddr_out`=`CHANNEL_ADDR`. Clear the timeout counter, then go to WAIT.
- **WAIT:**
  - On `drdy_in`=1, capture `do_in[15:4]` as `code`.
  - If the capture completes the decimation count, go to EMIT. Otherwise increment the decimation counter and go to IDLE.
  - If the timeout counter reaches `DRDY_TIMEOUT` with no `drdy_in`, set `timeout_err` and go to IDLE. No sample is emitted and the decimation counter is unchanged.
- **EMIT:**
  - Drive `sampleOUT` with the conversion below and pulse `SAMPLEoutReady` for one cycle.
  - Increment `sample_count`, clear the decimation counter, go to IDLE.
- **Conversion:**
  - `BIPOLAR`=1: `sampleOUT` = `code`.
  - `BIPOLAR`=0: `sampleOUT` = {~`code`[11], `code`[10:0]}, i.e. `code` − 2048. 0x000 maps to −2048, 0x800 to 0, 0xFFF to +2047.
  - No saturation is needed.
- **Overrun:** an event in REQ, WAIT or EMIT sets `overrun` and is dropped. It is not queued.
- **`enable` deasserted mid-read:** the DRP read still completes, because the DRP protocol requires it. The captured value is discarded and no EMIT occurs.
- **`drdy_in` outside WAIT:** ignored.
- **DRP writes:** the block never issues writes.

## Timing
- **Reset (`rst`=0 at a clock edge):**
  - State goes to IDLE.
  - `den_out`=0, `daddr_out`=`CHANNEL_ADDR`, `sampleOUT`=0, `SAMPLEoutReady`=0, `overrun`=0, `timeout_err`=0, `sample_count`=0.
  - Decimation counter, timeout counter and the EOC register are cleared.
  - Reset during WAIT abandons the read, and a late `drdy_in` after reset is ignored.
- **Latency:** `eoc_in` rises and is sampled at edge T.
  - Edge detected at T+1.
  - `den_out` high in cycle T+2.
  - `drdy_in` seen at edge D (D ≥ T+3).
  - `SAMPLEoutReady` and the new `sampleOUT` are valid in cycle D+1.
- **Output holding:** `sampleOUT` holds its value between strobes. `SAMPLEoutReady` is never high on consecutive cycles.
- **Timeout:** `timeout_err` is set on the edge where `DRDY_TIMEOUT` cycles have elapsed after `den_out`.
- **Consumer handshake:** the consumer must accept on the strobe. There is no backpressure.
- **Sticky flags:** `overrun` and `timeout_err` clear only on reset.

## Test plan
- **Bipolar pass-through:** `BIPOLAR`=1. EOC, then `drdy_in` 3 cycles after `den_out` with `do_in`=16'hFFF0 → `den_out` pulses once with `daddr_out`=7'h03; `sampleOUT`=−1 with `SAMPLEoutReady` one cycle after `drdy_in`; `sample_count`=1.
- **Unipolar conversion:** `BIPOLAR`=0. Three reads with `do_in`[15:4] = 0x000, 0x800, 0xFFF → outputs −2048, 0, +2047.
- **Decimation:** `DECIMATION`=4, 8 EOCs each answered by DRP → exactly 2 strobes, carrying the 4th and 8th codes.
- **Timeout:** `DRDY_TIMEOUT`=8, no `drdy_in` → `timeout_err`=1 eight cycles after `den_out`; no strobe; the next EOC completes normally.
- **Overrun:** second EOC while in WAIT → `overrun`=1; only one `den_out`; one strobe.
- **Reset and enable mid-read:**
  - `rst`=0 in WAIT, then `drdy_in` → all outputs at reset values; no strobe.
  - `enable` dropped in WAIT → read completes; no strobe.
